// File: rtl/idecode_if.sv
// Bundle between the IF/ID latch, MEM/WB writeback and the ID/EX latch of the decode stage.
interface idecode_if #(
   parameter int unsigned DATA_W = 32
);
   logic [31:0]       IF_ID_instr;
   logic [31:0]       IF_ID_npc;
   logic              MEM_WB_RegWrite;
   logic [4:0]        MEM_WB_WriteReg;
   logic [DATA_W-1:0] MEM_WB_WriteData;
   logic [1:0]        ID_EX_WB;
   logic [2:0]        ID_EX_M;
   logic [3:0]        ID_EX_EX;
   logic [31:0]       ID_EX_npc;
   logic [DATA_W-1:0] ID_EX_readdat1;
   logic [DATA_W-1:0] ID_EX_readdat2;
   logic [31:0]       ID_EX_sign_ext;
   logic [4:0]        ID_EX_instr_2016;
   logic [4:0]        ID_EX_instr_1511;
   logic              ID_stall;

   modport master (
      output IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
      input  ID_EX_WB, ID_EX_M, ID_EX_EX, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
      input  ID_EX_sign_ext, ID_EX_instr_2016, ID_EX_instr_1511, ID_stall
   );

   modport slave (
      input  IF_ID_instr, IF_ID_npc, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_WriteData,
      output ID_EX_WB, ID_EX_M, ID_EX_EX, ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2,
      output ID_EX_sign_ext, ID_EX_instr_2016, ID_EX_instr_1511, ID_stall
   );
endinterface

// File: rtl/idecode.sv
// MIPS-style decode stage: control decode, register file with write-through bypass, ID/EX latch.
// Define HAZARD_DETECT_EN to add load-use stall detection with bubble insertion.
module idecode #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_CNT = 32
) (
   input logic       clk,
   input logic       rst_n,
   idecode_if.slave  bus
);

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;

   logic [5:0]        opcode;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [1:0]        dec_wb;
   logic [2:0]        dec_m;
   logic [3:0]        dec_ex;
   logic              wr_en;
   logic              stall;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] rf_q [REG_CNT];

   logic [1:0]        wb_d, wb_q;
   logic [2:0]        m_d, m_q;
   logic [3:0]        ex_d, ex_q;
   logic [31:0]       npc_d, npc_q;
   logic [DATA_W-1:0] rd1_d, rd1_q;
   logic [DATA_W-1:0] rd2_d, rd2_q;
   logic [31:0]       sext_d, sext_q;
   logic [4:0]        rt_d, rt_q;
   logic [4:0]        rd_d, rd_q;

   assign opcode = bus.IF_ID_instr[31:26];
   assign rs     = bus.IF_ID_instr[25:21];
   assign rt     = bus.IF_ID_instr[20:16];
   assign rd     = bus.IF_ID_instr[15:11];

   always_comb begin
      dec_wb = 2'b00;
      dec_m  = 3'b000;
      dec_ex = 4'b0000;
      unique case (opcode)
         OpRtype: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b1100; end
         OpLw:    begin dec_wb = 2'b11; dec_m = 3'b010; dec_ex = 4'b0001; end
         OpSw:    begin dec_wb = 2'b00; dec_m = 3'b001; dec_ex = 4'b0001; end
         OpBeq:   begin dec_wb = 2'b00; dec_m = 3'b100; dec_ex = 4'b0010; end
         default: begin dec_wb = 2'b00; dec_m = 3'b000; dec_ex = 4'b0000; end
      endcase
   end

   // Register 0 is never written, so it stays at its reset value of zero.
   assign wr_en = bus.MEM_WB_RegWrite && (bus.MEM_WB_WriteReg != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_CNT; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_en) begin
         rf_q[bus.MEM_WB_WriteReg] <= bus.MEM_WB_WriteData;
      end
   end

   always_comb begin
      rs_data = rf_q[rs];
      if (rs == 5'd0) begin
         rs_data = '0;
      end else if (wr_en && (bus.MEM_WB_WriteReg == rs)) begin
         rs_data = bus.MEM_WB_WriteData;
      end
   end

   always_comb begin
      rt_data = rf_q[rt];
      if (rt == 5'd0) begin
         rt_data = '0;
      end else if (wr_en && (bus.MEM_WB_WriteReg == rt)) begin
         rt_data = bus.MEM_WB_WriteData;
      end
   end

`ifdef HAZARD_DETECT_EN
   // Load in EX whose destination feeds this instruction: hold fetch and bubble EX.
   assign stall = m_q[1] && (rt_q != 5'd0) && ((rt_q == rs) || (rt_q == rt));
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      wb_d   = stall ? 2'b00 : dec_wb;
      m_d    = stall ? 3'b000 : dec_m;
      ex_d   = stall ? 4'b0000 : dec_ex;
      npc_d  = bus.IF_ID_npc;
      rd1_d  = rs_data;
      rd2_d  = rt_data;
      sext_d = {{16{bus.IF_ID_instr[15]}}, bus.IF_ID_instr[15:0]};
      rt_d   = rt;
      rd_d   = rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q   <= '0;
         m_q    <= '0;
         ex_q   <= '0;
         npc_q  <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         sext_q <= '0;
         rt_q   <= '0;
         rd_q   <= '0;
      end else begin
         wb_q   <= wb_d;
         m_q    <= m_d;
         ex_q   <= ex_d;
         npc_q  <= npc_d;
         rd1_q  <= rd1_d;
         rd2_q  <= rd2_d;
         sext_q <= sext_d;
         rt_q   <= rt_d;
         rd_q   <= rd_d;
      end
   end

   assign bus.ID_EX_WB         = wb_q;
   assign bus.ID_EX_M          = m_q;
   assign bus.ID_EX_EX         = ex_q;
   assign bus.ID_EX_npc        = npc_q;
   assign bus.ID_EX_readdat1   = rd1_q;
   assign bus.ID_EX_readdat2   = rd2_q;
   assign bus.ID_EX_sign_ext   = sext_q;
   assign bus.ID_EX_instr_2016 = rt_q;
   assign bus.ID_EX_instr_1511 = rd_q;
   assign bus.ID_stall         = stall;

endmodule

// File: tb/tb_idecode.sv
// Scoreboard bench for idecode: stimulus queues expected ID/EX contents, a monitor checks them.
module tb_idecode;

`ifdef HAZARD_DETECT_EN
   localparam bit Hz = 1'b1;
`else
   localparam bit Hz = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] npc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sext;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc_cnt = 0;
   int   n_cmp   = 0;
   int   n_bad   = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   idecode_if bus ();

   idecode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Monitor: compare each queued entry right after the edge that should have loaded it.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
         mon_e = exp_q.pop_front();
         chk("entry_cycle", mon_e.cyc, cyc_cnt);
         chk("WB",        {30'd0, bus.ID_EX_WB},         {30'd0, mon_e.wb});
         chk("M",         {29'd0, bus.ID_EX_M},          {29'd0, mon_e.m});
         chk("EX",        {28'd0, bus.ID_EX_EX},         {28'd0, mon_e.ex});
         chk("npc",       bus.ID_EX_npc,                 mon_e.npc);
         chk("readdat1",  bus.ID_EX_readdat1,            mon_e.rd1);
         chk("readdat2",  bus.ID_EX_readdat2,            mon_e.rd2);
         chk("sign_ext",  bus.ID_EX_sign_ext,            mon_e.sext);
         chk("instr_2016", {27'd0, bus.ID_EX_instr_2016}, {27'd0, mon_e.rt});
         chk("instr_1511", {27'd0, bus.ID_EX_instr_1511}, {27'd0, mon_e.rd});
      end
   end

   task automatic issue(input logic [31:0] instr, input logic [31:0] npc, input logic we,
                        input logic [4:0] wreg, input logic [31:0] wdata, input logic stall_exp,
                        input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] sext);
      exp_t e;
      @(negedge clk);
      bus.IF_ID_instr      = instr;
      bus.IF_ID_npc        = npc;
      bus.MEM_WB_RegWrite  = we;
      bus.MEM_WB_WriteReg  = wreg;
      bus.MEM_WB_WriteData = wdata;
      e.cyc  = cyc_cnt + 1;
      e.wb   = wb;
      e.m    = m;
      e.ex   = ex;
      e.npc  = npc;
      e.rd1  = rd1;
      e.rd2  = rd2;
      e.sext = sext;
      e.rt   = instr[20:16];
      e.rd   = instr[15:11];
      exp_q.push_back(e);
      #1;
      chk("ID_stall", {31'd0, bus.ID_stall}, {31'd0, stall_exp});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_WB"},   {30'd0, bus.ID_EX_WB}, 32'd0);
      chk({tag, "_M"},    {29'd0, bus.ID_EX_M}, 32'd0);
      chk({tag, "_EX"},   {28'd0, bus.ID_EX_EX}, 32'd0);
      chk({tag, "_npc"},  bus.ID_EX_npc, 32'd0);
      chk({tag, "_rd1"},  bus.ID_EX_readdat1, 32'd0);
      chk({tag, "_rd2"},  bus.ID_EX_readdat2, 32'd0);
      chk({tag, "_sext"}, bus.ID_EX_sign_ext, 32'd0);
      chk({tag, "_rt"},   {27'd0, bus.ID_EX_instr_2016}, 32'd0);
      chk({tag, "_rd"},   {27'd0, bus.ID_EX_instr_1511}, 32'd0);
      chk({tag, "_stall"}, {31'd0, bus.ID_stall}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0]  hwb;
      logic [3:0]  hex;
      logic [31:0] ins;
      rst_n                = 1'b0;
      bus.IF_ID_instr      = 32'h8C41_0004;
      bus.IF_ID_npc        = 32'h0000_0040;
      bus.MEM_WB_RegWrite  = 1'b1;
      bus.MEM_WB_WriteReg  = 5'd2;
      bus.MEM_WB_WriteData = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed sequence: write $2, lw, beq, same-cycle bypass, $0 write, other opcodes.
      issue(32'h0000_0000, 32'h04, 1'b1, 5'd2, 32'h10, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0);
      issue(32'h8C41_0004, 32'h08, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b11, 3'b010, 4'b0001, 32'h10, 32'h0, 32'h4);
      issue(32'h0000_0000, 32'h0C, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0);
      issue(32'h1022_FFFC, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b00, 3'b100, 4'b0010, 32'h0, 32'h10, 32'hFFFF_FFFC);
      issue(32'h0061_1020, 32'h14, 1'b1, 5'd3, 32'hDEAD, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'hDEAD, 32'h0, 32'h1020);
      issue(32'h0003_0000, 32'h18, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'hDEAD, 32'h0);
      issue(32'h0000_0000, 32'h1C, 1'b0, 5'd4, 32'hBAD, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0);
      issue(32'h0083_0000, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'hDEAD, 32'h0);
      issue(32'h0800_0000, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0);
      issue(32'hAC43_0008, 32'h28, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b00, 3'b001, 4'b0001, 32'h10, 32'hDEAD, 32'h8);
      issue(32'h8C00_8000, 32'h2C, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b11, 3'b010, 4'b0001, 32'h0, 32'h0, 32'hFFFF_8000);
      // Load to $0 is never a hazard even though this instruction reads $0.
      issue(32'h0000_0000, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0);

      // Load-use pair: lw $1 then add reading $1.
      hwb = Hz ? 2'b00 : 2'b10;
      hex = Hz ? 4'b0000 : 4'b1100;
      issue(32'h8C41_0004, 32'h34, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b11, 3'b010, 4'b0001, 32'h10, 32'h0, 32'h4);
      issue(32'h0022_1820, 32'h38, 1'b0, 5'd0, 32'h0, Hz,
            hwb, 3'b000, hex, 32'h0, 32'h10, 32'h1820);
      issue(32'h0022_1820, 32'h38, 1'b0, 5'd0, 32'h0, 1'b0,
            2'b10, 3'b000, 4'b1100, 32'h0, 32'h10, 32'h1820);

      // Mid-stream asynchronous reset with a lw already latched.
      @(negedge clk);
      bus.IF_ID_instr     = 32'h8C41_0004;
      bus.IF_ID_npc       = 32'h3C;
      bus.MEM_WB_RegWrite = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_reset_WB", {30'd0, bus.ID_EX_WB}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i < 32; i++) begin
         ins = 32'd0;
         ins[25:21] = 5'(i);
         ins[20:16] = 5'(i);
         issue(ins, 32'h100 + 32'(4 * i), 1'b0, 5'd0, 32'h0, 1'b0,
               2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'h0);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 The block SHALL have parameter REG_CNT, default 32, register-file depth (5-bit index).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port IF_ID_instr  input  32  instruction from the IF/ID latch.
REQ-006 The block SHALL have port IF_ID_npc  input  32  PC+4 from the IF/ID latch.
REQ-007 The block SHALL have port MEM_WB_RegWrite  input  1  writeback enable.
REQ-008 The block SHALL have port MEM_WB_WriteReg  input  5  writeback register index.
REQ-009 The block SHALL have port MEM_WB_WriteData  input  32  writeback data.
REQ-010 The block SHALL have port ID_EX_WB  output  2  {RegWrite, MemtoReg}.
REQ-011 The block SHALL have port ID_EX_M  output  3  {Branch, MemRead, MemWrite}.
REQ-012 The block SHALL have port ID_EX_EX  output  4  {RegDst, ALUOp[1:0], ALUSrc}.
REQ-013 The block SHALL have ports ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext  output  32 each  latched npc, rs data, rt data, sign-extended imm.
REQ-014 The block SHALL have ports ID_EX_instr_2016, ID_EX_instr_1511  output  5 each  latched rt, rd fields.
REQ-015 The block SHALL have port ID_stall  output  1  hold request to fetch (combinational).

Function
REQ-016 Decode SHALL use opcode IF_ID_instr[31:26]: 0x00 R-type WB=10 M=000 EX=1100; 0x23 lw WB=11 M=010 EX=0001; 0x2B sw WB=00 M=001 EX=0001; 0x04 beq WB=00 M=100 EX=0010; any other opcode all-zero.
REQ-017 The register file SHALL hold REG_CNT x DATA_W entries, written on rising clk when MEM_WB_RegWrite=1 and MEM_WB_WriteReg!=0.
REQ-018 Register 0 SHALL always read 0; writes to it SHALL be ignored.
REQ-019 Reads of rs=[25:21] and rt=[20:16] SHALL be combinational with write-through bypass: same-cycle write to a matching nonzero index returns MEM_WB_WriteData.
REQ-020 Sign extension SHALL replicate bit [15] into bits [31:16].
REQ-021 All ID_EX_* outputs SHALL load on the rising clk edge: exactly one cycle latency from IF_ID_* to ID_EX_*.
REQ-022 A bubble SHALL force ID_EX_WB, ID_EX_M and ID_EX_EX to zero on the loading edge; data fields load normally.
REQ-023 Writeback SHALL proceed regardless of stall/bubble in the same cycle.

Reset
REQ-024 While rst_n=0, all ID_EX_* outputs and all register-file entries SHALL be 0, asynchronously, including mid-operation.
REQ-025 ID_stall SHALL be 0 during reset; the first rising edge after rst_n rises SHALL load normally.

Configuration
REQ-026 Macro HAZARD_DETECT_EN defined: ID_stall=1 when ID_EX_M[1]=1 and ID_EX_instr_2016!=0 and ID_EX_instr_2016 equals instr[25:21] or instr[20:16]; while 1, the next edge inserts a bubble (REQ-022); fetch holds the instruction.
REQ-027 Macro HAZARD_DETECT_EN undefined: ID_stall SHALL be constant 0, no bubbles inserted, no detection logic present.

Verification
REQ-028 Reset: rst_n=0 mid-stream -> all ID_EX_* = 0 immediately; reads of $1..$31 return 0.
REQ-029 Writeback $2=0x00000010, then instr 0x8C410004 (lw $1,4($2)), npc=0x8 -> next edge: readdat1=0x10, sign_ext=0x4, instr_2016=1, WB=11, M=010, EX=0001, npc=0x8.
REQ-030 Instr 0x1022FFFC (beq $1,$2,-4) -> sign_ext=0xFFFFFFFC, M=100, EX=0010, WB=00.
REQ-031 Same cycle: writeback $3=0x0000DEAD and instr 0x00611020 (add $2,$3,$1) -> readdat1=0x0000DEAD; writeback $0=0xFFFFFFFF -> subsequent read of $0 returns 0.
REQ-032 HAZARD_DETECT_EN: lw 0x8C410004 then add 0x00221820 -> ID_stall=1 during add cycle, next ID_EX WB/M/EX=0; add re-presented -> ID_stall=0, EX=1100. Without the macro -> ID_stall stays 0, no bubble.
